lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/rv64_pkg.sv | 41 ++++
 rtl/load_align.sv | 30 +++
 rtl/lsu_controller.sv | 112 +++++++++++
 tb/tb_lsu_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// Shared RV64 load/store encodings, LSU state type and access-size helpers.
package rv64_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  // Byte-enable pattern for an access of size 2**sz bytes at offset 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      2'b11:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed bytes from an aligned doubleword and sign/zero extends them.
module load_align
  import rv64_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] rdata,
  input  logic [2:0]        off,
  input  logic [2:0]        funct3,
  output logic [ADDR_W-1:0] data
);

  logic [ADDR_W-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:  data = {{(ADDR_W-8){shifted[7]}},   shifted[7:0]};
      F3_H:  data = {{(ADDR_W-16){shifted[15]}}, shifted[15:0]};
      F3_W:  data = {{(ADDR_W-32){shifted[31]}}, shifted[31:0]};
      F3_BU: data = {{(ADDR_W-8){1'b0}},         shifted[7:0]};
      F3_HU: data = {{(ADDR_W-16){1'b0}},        shifted[15:0]};
      F3_WU: data = {{(ADDR_W-32){1'b0}},        shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Single-outstanding RV64 load/store unit: address generation, alignment checks,
// one memory request per instruction and a one-cycle response to writeback.
module lsu_controller
  import rv64_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] rs1_data,
  input  logic [ADDR_W-1:0] rs2_data,
  input  logic [11:0]       imm,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_data,
  output logic              rsp_err
);

  lsu_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] ea;
  logic [2:0]        off;
  logic              is_load, is_store, illegal, req_err, accept;
  logic [ADDR_W-1:0] addr_reg, wdata_reg, rsp_data_reg, load_data;
  logic [7:0]        wmask_reg;
  logic              we_reg, rsp_err_reg;
  logic [2:0]        off_reg, funct3_reg;

  assign ea       = rs1_data + {{(ADDR_W-12){imm[11]}}, imm};
  assign off      = ea[2:0];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign illegal  = !(is_load || is_store)
                  || (is_load && funct3 == 3'b111)
                  || (is_store && funct3[2]);
  // Unsigned loads share size encoding in funct3[1:0] with their signed forms.
  assign req_err  = illegal || is_misaligned(funct3[1:0], off);
  assign accept   = req_valid && (state_reg == IDLE);

  load_align #(.ADDR_W(ADDR_W)) u_load_align (
    .rdata  (mem_rdata),
    .off    (off_reg),
    .funct3 (funct3_reg),
    .data   (load_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = req_err ? RESP : ISSUE;
      ISSUE:   if (mem_ready) state_next = we_reg ? RESP : WAIT;
      WAIT:    if (mem_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wmask_reg    <= '0;
      we_reg       <= 1'b0;
      off_reg      <= '0;
      funct3_reg   <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg     <= {ea[ADDR_W-1:3], 3'b000};
            wdata_reg    <= rs2_data << {off, 3'b000};
            wmask_reg    <= size_mask(funct3[1:0]) << off;
            we_reg       <= is_store && !req_err;
            off_reg      <= off;
            funct3_reg   <= funct3;
            rsp_err_reg  <= req_err;
            rsp_data_reg <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid) rsp_data_reg <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign mem_valid = (state_reg == ISSUE);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wmask = wmask_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: loads, stores, stalls, error paths and mid-flight reset.
module tb_lsu_controller;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data;
  logic [11:0] imm;
  logic        mem_valid, mem_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_controller #(.ADDR_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] byte_mask(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [11:0] im, input string tag);
    check_eq({tag, "_req_ready"}, {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    opcode = op; funct3 = f3; rs1_data = r1; rs2_data = r2; imm = im;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [63:0] r1, input logic [11:0] im,
                         input logic [63:0] rdata, input logic [63:0] exp_addr,
                         input logic [63:0] exp_data, input string tag);
    issue(LOAD, f3, r1, 64'h0, im, tag);
    check_eq({tag, "_mem_valid"}, {63'b0, mem_valid}, 64'd1);
    check_eq({tag, "_mem_addr"}, mem_addr, exp_addr);
    check_eq({tag, "_mem_we"}, {63'b0, mem_we}, 64'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq({tag, "_wait_no_valid"}, {63'b0, mem_valid}, 64'd0);
    check_eq({tag, "_wait_no_rsp"}, {63'b0, rsp_valid}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
    check_eq({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd1);
    check_eq({tag, "_rsp_err"}, {63'b0, rsp_err}, 64'd0);
    check_eq({tag, "_rsp_data"}, rsp_data, exp_data);
    tick();
    check_eq({tag, "_rsp_one_cycle"}, {63'b0, rsp_valid}, 64'd0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [63:0] r1, input logic [11:0] im,
                          input logic [63:0] r2, input int stall, input logic [63:0] exp_addr,
                          input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                          input string tag);
    issue(STORE, f3, r1, r2, im, tag);
    for (int i = 0; i <= stall; i++) begin
      check_eq($sformatf("%s_c%0d_mem_valid", tag, i), {63'b0, mem_valid}, 64'd1);
      check_eq($sformatf("%s_c%0d_mem_we", tag, i), {63'b0, mem_we}, 64'd1);
      check_eq($sformatf("%s_c%0d_mem_addr", tag, i), mem_addr, exp_addr);
      check_eq($sformatf("%s_c%0d_mem_wmask", tag, i), {56'b0, mem_wmask}, {56'b0, exp_mask});
      check_eq($sformatf("%s_c%0d_mem_wdata", tag, i), mem_wdata & byte_mask(exp_mask), exp_wdata);
      if (i == stall) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check_eq({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd1);
    check_eq({tag, "_single_accept"}, {63'b0, mem_valid}, 64'd0);
    check_eq({tag, "_rsp_err"}, {63'b0, rsp_err}, 64'd0);
    check_eq({tag, "_rsp_data"}, rsp_data, 64'h0);
    tick();
    check_eq({tag, "_rsp_one_cycle"}, {63'b0, rsp_valid}, 64'd0);
  endtask

  task automatic do_err(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] r1,
                        input logic [11:0] im, input string tag);
    issue(op, f3, r1, 64'hFFFF_FFFF_FFFF_FFFF, im, tag);
    check_eq({tag, "_mem_valid"}, {63'b0, mem_valid}, 64'd0);
    check_eq({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd1);
    check_eq({tag, "_rsp_err"}, {63'b0, rsp_err}, 64'd1);
    check_eq({tag, "_rsp_data"}, rsp_data, 64'h0);
    tick();
    check_eq({tag, "_idle_again"}, {63'b0, req_ready}, 64'd1);
    check_eq({tag, "_no_mem"}, {63'b0, mem_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; opcode = '0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_valid", {63'b0, mem_valid}, 64'd0);
    check_eq("rst_mem_we", {63'b0, mem_we}, 64'd0);
    check_eq("rst_mem_wmask", {56'b0, mem_wmask}, 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    check_eq("rst_mem_wdata", mem_wdata, 64'd0);
    check_eq("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check_eq("rst_rsp_data", rsp_data, 64'd0);
    check_eq("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
    rst = 1'b0;
    tick();

    // lw at 0x1004: upper word 0x80000000 sign-extends
    do_load(3'b010, 64'h1000, 12'h004, 64'h8000_0000_0000_0000, 64'h1000,
            64'hFFFF_FFFF_8000_0000, "lw");
    // sb to byte 3 with one stall cycle
    do_store(3'b000, 64'h2003, 12'h000, 64'h0000_0000_0000_00AB, 1, 64'h2000, 8'h08,
             64'h0000_0000_AB00_0000, "sb");
    do_err(LOAD, 3'b001, 64'h3001, 12'h000, "lh_misaligned");
    // sd held for three stall cycles before acceptance
    do_store(3'b011, 64'h5000, 12'h008, 64'h1122_3344_5566_7788, 3, 64'h5008, 8'hFF,
             64'h1122_3344_5566_7788, "sd_stall");
    do_load(3'b100, 64'h4007, 12'h000, 64'hFE00_0000_0000_0000, 64'h4000,
            64'h0000_0000_0000_00FE, "lbu");
    // negative immediate: 0x1000 + (-0x800) = 0x800
    do_load(3'b011, 64'h1000, 12'h800, 64'hDEAD_BEEF_CAFE_F00D, 64'h0800,
            64'hDEAD_BEEF_CAFE_F00D, "ld_negimm");
    do_load(3'b101, 64'h7000, 12'h006, 64'hBEEF_0000_0000_0000, 64'h7000,
            64'h0000_0000_0000_BEEF, "lhu");
    do_store(3'b001, 64'h8000, 12'h006, 64'h0000_0000_0000_CAFE, 0, 64'h8000, 8'hC0,
             64'hCAFE_0000_0000_0000, "sh");
    do_store(3'b010, 64'h9008, 12'hFFC, 64'h0000_0000_1234_5678, 0, 64'h9000, 8'hF0,
             64'h1234_5678_0000_0000, "sw_negimm");
    do_err(7'b0110011, 3'b000, 64'h1000, 12'h000, "bad_opcode");
    do_err(STORE, 3'b100, 64'h1000, 12'h000, "store_f3_4");
    do_err(LOAD, 3'b111, 64'h1000, 12'h000, "load_f3_7");
    do_err(LOAD, 3'b010, 64'h1002, 12'h000, "lw_misaligned");
    do_err(LOAD, 3'b011, 64'h1004, 12'h000, "ld_misaligned");

    // reset while waiting for load data; late rvalid must be ignored
    issue(LOAD, 3'b010, 64'h1000, 64'h0, 12'h004, "rstwait");
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstwait_mem_valid", {63'b0, mem_valid}, 64'd0);
    check_eq("rstwait_mem_addr", mem_addr, 64'd0);
    check_eq("rstwait_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 64'h8000_0000_0000_0000;
    tick();
    mem_rvalid = 1'b0;
    check_eq("rstwait_late_rvalid", {63'b0, rsp_valid}, 64'd0);
    check_eq("rstwait_req_ready", {63'b0, req_ready}, 64'd1);
    check_eq("rstwait_rsp_data", rsp_data, 64'd0);
    tick();
    check_eq("rstwait_still_quiet", {63'b0, rsp_valid}, 64'd0);

    do_load(3'b000, 64'h6001, 12'h000, 64'h0000_0000_0000_8000, 64'h6000,
            64'hFFFF_FFFF_FFFF_FF80, "lb_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
